// File: rtl/bus_responder.sv
// bus_responder: half-duplex bus endpoint that hunts SOF, streams a fixed payload, then answers with ACK.
// Define BUS_RESPONDER_CHECKSUM_EN to append the payload checksum to the response.
module bus_responder #(
    parameter int unsigned PAYLOAD_LEN = 4,
    parameter int unsigned TURNAROUND  = 2,
    parameter logic [7:0]  SOF_BYTE    = 8'h3A,
    parameter logic [7:0]  ACK_BYTE    = 8'h06
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       peer_oe_i,
    inout  wire  [7:0] data_line_io,
    output logic       tx_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_done_o,
    output logic       frame_err_o,
    output logic       bus_conflict_o,
    output logic [7:0] checksum_o
);
    localparam int TW = $clog2(TURNAROUND + 1);
    typedef enum logic [2:0] {IDLE, PAYLOAD, WAIT_REL, TURN, RESP} state_t;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d, tx_byte_q, tx_byte_d, rx_data_q, rx_data_d, bus_in;
    logic [TW-1:0] turn_q, turn_d;
    logic tx_oe_q, tx_oe_d, rx_valid_q, rx_valid_d, done_q, done_d, err_q, err_d, conf_q, conf_d;
`ifdef BUS_RESPONDER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d, chk_q, chk_d;
    assign checksum_o = chk_q;
`else
    assign checksum_o = 8'h00;
`endif
    assign data_line_io   = tx_oe_q ? tx_byte_q : 8'bz;
    assign bus_in         = data_line_io;
    assign tx_oe_o        = tx_oe_q;
    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign frame_done_o   = done_q;
    assign frame_err_o    = err_q;
    assign bus_conflict_o = conf_q;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        turn_d     = turn_q;
        tx_oe_d    = tx_oe_q;
        tx_byte_d  = tx_byte_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        conf_d     = 1'b0;
`ifdef BUS_RESPONDER_CHECKSUM_EN
        sum_d      = sum_q;
        chk_d      = chk_q;
`endif
        case (state_q)
            IDLE: if (peer_oe_i && bus_in == SOF_BYTE) begin
                state_d = PAYLOAD;
                cnt_d   = 8'd0;
`ifdef BUS_RESPONDER_CHECKSUM_EN
                sum_d   = 8'd0;
`endif
            end
            PAYLOAD: if (peer_oe_i) begin
                rx_data_d  = bus_in;
                rx_valid_d = 1'b1;
                cnt_d      = cnt_q + 8'd1;
`ifdef BUS_RESPONDER_CHECKSUM_EN
                sum_d      = sum_q + bus_in;
`endif
                if (cnt_q == 8'(PAYLOAD_LEN - 1)) begin
                    done_d  = 1'b1;
                    state_d = WAIT_REL;
`ifdef BUS_RESPONDER_CHECKSUM_EN
                    chk_d   = sum_q + bus_in;
`endif
                end
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            WAIT_REL: if (!peer_oe_i) begin
                state_d = TURN;
                turn_d  = TW'(1);
            end
            TURN: if (peer_oe_i) begin
                state_d = IDLE;
            end else if (turn_q == TW'(TURNAROUND)) begin
                state_d   = RESP;
                tx_oe_d   = 1'b1;
                tx_byte_d = ACK_BYTE;
                turn_d    = '0;
            end else begin
                turn_d = turn_q + 1'b1;
            end
            // turn_q doubles as the response byte index
            RESP: if (peer_oe_i) begin
                tx_oe_d = 1'b0;
                conf_d  = 1'b1;
                state_d = IDLE;
`ifdef BUS_RESPONDER_CHECKSUM_EN
            end else if (turn_q == '0) begin
                tx_byte_d = chk_q;
                turn_d    = TW'(1);
`endif
            end else begin
                tx_oe_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            turn_q     <= '0;
            tx_oe_q    <= 1'b0;
            tx_byte_q  <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            conf_q     <= 1'b0;
`ifdef BUS_RESPONDER_CHECKSUM_EN
            sum_q      <= 8'd0;
            chk_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            turn_q     <= turn_d;
            tx_oe_q    <= tx_oe_d;
            tx_byte_q  <= tx_byte_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            conf_q     <= conf_d;
`ifdef BUS_RESPONDER_CHECKSUM_EN
            sum_q      <= sum_d;
            chk_q      <= chk_d;
`endif
        end
    end
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: randomized frame-level bench; expectations come from payload lists, not cycle state.
// Honours BUS_RESPONDER_CHECKSUM_EN the same way the design does.
module tb_bus_responder;
    localparam int LEN = 4;
    localparam int T   = 2;
    localparam logic [7:0] SOF = 8'h3A;
    localparam logic [7:0] ACK = 8'h06;
`ifdef BUS_RESPONDER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, peer_oe = 1'b0;
    logic [7:0] peer_data = 8'h00;
    wire  [7:0] bus;
    logic tx_oe, rx_valid, done, err, conf;
    logic [7:0] rx_data, chk_o;
    int n_chk = 0, n_fail = 0, cyc_n = 0;
    logic [7:0] pay_q[$], rx_obs[$], tx_obs[$];
    int n_done = 0, n_err = 0, n_conf = 0, first_tx = -1;
    logic p_done = 1'b0, p_err = 1'b0, p_conf = 1'b0, p_tx = 1'b0;
    logic [7:0] last_chk = 8'h00;
    assign bus = peer_oe ? peer_data : 8'bz;
    bus_responder #(.PAYLOAD_LEN(LEN), .TURNAROUND(T), .SOF_BYTE(SOF), .ACK_BYTE(ACK)) dut (
        .clk_i(clk), .rst_i(rst), .peer_oe_i(peer_oe), .data_line_io(bus), .tx_oe_o(tx_oe),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .frame_done_o(done), .frame_err_o(err),
        .bus_conflict_o(conf), .checksum_o(chk_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rx_valid) rx_obs.push_back(rx_data);
        if (tx_oe) tx_obs.push_back(bus);
        if (tx_oe && !p_tx && first_tx < 0) first_tx = cyc_n;
        n_done += int'(done);
        n_err  += int'(err);
        n_conf += int'(conf);
        check("strobe_width", {29'd0, done & p_done, err & p_err, conf & p_conf}, 32'd0);
        p_done = done; p_err = err; p_conf = conf; p_tx = tx_oe;
    end
    task automatic cyc(input logic oe, input logic [7:0] d);
        peer_oe = oe;
        peer_data = d;
        @(posedge clk);
        #1;
    endtask
    task automatic clear_mon();
        rx_obs.delete(); tx_obs.delete();
        n_done = 0; n_err = 0; n_conf = 0; first_tx = -1;
    endtask
    function automatic logic [7:0] sum8(input logic [7:0] q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return 8'(s);
    endfunction
    task automatic rand_pay(input int n);
        pay_q.delete();
        repeat (n) pay_q.push_back(8'($urandom));
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_tx_oe"}, tx_oe, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_strobes"}, {rx_valid, done, err, conf}, 0);
        check({tag, "_checksum"}, chk_o, 0);
    endtask
    task automatic wait_tx(input string tag);
        int k = 0;
        while (!tx_oe && k < 20) begin
            cyc(1'b0, 8'h00);
            k++;
        end
        check({tag, "_tx_up"}, tx_oe, 1);
    endtask
    task automatic frame(input string tag, input int nfill, input int ntrail);
        logic [7:0] b, exp_chk;
        bit full;
        int rel;
        clear_mon();
        repeat (nfill) begin
            b = 8'($urandom);
            if (b == SOF) b = 8'hFF;
            cyc(1'b1, b);
        end
        cyc(1'b1, SOF);
        foreach (pay_q[i]) cyc(1'b1, pay_q[i]);
        full = pay_q.size() == LEN;
        if (full) repeat (ntrail) cyc(1'b1, 8'($urandom));
        cyc(1'b0, 8'h00);
        rel = cyc_n;
        repeat (T + 5) cyc(1'b0, 8'h00);
        check({tag, "_rx_n"}, rx_obs.size(), pay_q.size());
        foreach (pay_q[i]) if (i < rx_obs.size()) check({tag, "_rx"}, rx_obs[i], pay_q[i]);
        exp_chk = (full && CK) ? sum8(pay_q) : last_chk;
        check({tag, "_done_n"}, n_done, full ? 1 : 0);
        check({tag, "_err_n"}, n_err, full ? 0 : 1);
        check({tag, "_tx_n"}, tx_obs.size(), full ? (CK ? 2 : 1) : 0);
        if (full && tx_obs.size() > 0) check({tag, "_ack"}, tx_obs[0], ACK);
        if (full && CK && tx_obs.size() > 1) check({tag, "_resp_chk"}, tx_obs[1], exp_chk);
        if (full) check({tag, "_turn_lat"}, first_tx - rel, T);
        check({tag, "_checksum"}, chk_o, exp_chk);
        check({tag, "_tx_idle"}, tx_oe, 0);
        last_chk = exp_chk;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) cyc(1'b0, 8'h00);
        check_zero("reset");
        rst = 1'b0;
        cyc(1'b0, 8'h00);
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        frame("nominal", 0, 0);
        pay_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        frame("filler", 2, 0);
        pay_q = '{8'h11, 8'h22};
        frame("short", 0, 0);
        pay_q = '{8'hFF, 8'hFF, 8'hFF, 8'h04};
        frame("wrap", 1, 0);
        pay_q = '{SOF, 8'h55, SOF, 8'hAA};
        frame("sof_in_data", 0, 2);
        rand_pay(LEN);
        clear_mon();
        cyc(1'b1, SOF);
        foreach (pay_q[i]) cyc(1'b1, pay_q[i]);
        cyc(1'b0, 8'h00);
        wait_tx("conf");
        cyc(1'b1, 8'hFF);
        check("conf_tx_drop", tx_oe, 0);
        check("conf_strobe", conf, 1);
        cyc(1'b0, 8'h00);
        check("conf_strobe_clr", conf, 0);
        repeat (3) cyc(1'b0, 8'h00);
        check("conf_n", n_conf, 1);
        check("conf_tx_cycles", tx_obs.size(), 1);
        if (CK) last_chk = sum8(pay_q);
        rand_pay(LEN);
        frame("after_conf", 0, 0);
        clear_mon();
        cyc(1'b1, SOF);
        cyc(1'b1, 8'h01);
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        check_zero("rst_mid");
        rst = 1'b0;
        repeat (3) cyc(1'b0, 8'h00);
        check("rst_mid_done_err", n_done + n_err, 0);
        last_chk = 8'h00;
        pay_q = '{8'h05, 8'h05, 8'h05, 8'h05};
        frame("rst_next", 0, 0);
        rand_pay(LEN);
        clear_mon();
        cyc(1'b1, SOF);
        foreach (pay_q[i]) cyc(1'b1, pay_q[i]);
        cyc(1'b0, 8'h00);
        wait_tx("rst_resp");
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        check_zero("rst_resp");
        rst = 1'b0;
        repeat (4) cyc(1'b0, 8'h00);
        check("rst_resp_tx_cycles", tx_obs.size(), 1);
        check("rst_resp_conf", n_conf, 0);
        last_chk = 8'h00;
        for (int f = 0; f < 16; f++) begin
            rand_pay(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LEN - 1)) : LEN);
            frame("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Far-end endpoint of the shared 8-bit half-duplex parallel bus.
- Listens while the peer drives the bus and detects a start-of-frame byte.
- Captures a fixed-length payload and streams it to local logic.
- After the peer releases the bus and a turnaround gap, it takes the bus and drives an acknowledge response.

Parameters:
- PAYLOAD_LEN, 4, payload bytes per frame after SOF; legal range 1..255.
- TURNAROUND, 2, idle cycles between peer release and responder drive; legal range >=1.
- SOF_BYTE, 8'h3A, start-of-frame marker.
- ACK_BYTE, 8'h06, first response byte.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- peer_oe_i  input  1  high while the peer drives data_line_io.
- data_line_io  inout  8  shared bus; driven only while tx_oe_o=1, otherwise 8'bZ.
- tx_oe_o  output  1  responder is driving the bus.
- rx_data_o  output  8  captured payload byte.
- rx_valid_o  output  1  one-cycle strobe, rx_data_o valid.
- frame_done_o  output  1  one-cycle strobe, full payload received.
- frame_err_o  output  1  one-cycle strobe, peer released early.
- bus_conflict_o  output  1  one-cycle strobe, peer drove during response.
- checksum_o  output  8  mod-256 sum of last completed payload, held.

Behaviour:
- Reset (rst_i=1 at clock edge): state=IDLE.
  - tx_oe_o=0, rx_data_o=8'h00, rx_valid_o=0, frame_done_o=0, frame_err_o=0, bus_conflict_o=0, checksum_o=8'h00.
  - Internal count and sum cleared.
  - Reset wins over every other event.
- Bus sampling: data_line_io sampled directly at the edge (same clock domain as peer), only when peer_oe_i=1.
- All outputs are registered.
- Tri-state: data_line_io = tx_oe_o ? tx byte register : 8'bZ.
- States:
  - IDLE:
    - peer_oe_i=1 and byte==SOF_BYTE -> PAYLOAD, count=0, sum=0.
    - Any other byte (e.g. 8'hFF filler) is ignored.
  - PAYLOAD, each edge:
    - peer_oe_i=1: rx_data_o<=byte, rx_valid_o<=1, sum+=byte (8-bit wrap), count++.
      - On byte PAYLOAD_LEN: frame_done_o<=1 (same cycle as last rx_valid_o), checksum_o<=final sum -> WAIT_REL.
    - peer_oe_i=0 with count<PAYLOAD_LEN: frame_err_o<=1 -> IDLE; checksum_o unchanged.
    - A SOF_BYTE value inside the payload is data, not a restart.
  - WAIT_REL:
    - Bytes ignored.
    - peer_oe_i=0 -> TURN, turnaround counter=1.
  - TURN:
    - Bus released.
    - Counter reaches TURNAROUND with peer_oe_i=0 -> RESP; tx_oe_o=1 and ACK_BYTE appear together on the next cycle.
    - peer_oe_i=1 during TURN -> IDLE, no strobe; that edge's byte is not treated as SOF.
  - RESP:
    - Drive ACK_BYTE for 1 cycle, then checksum_o for 1 cycle (see optional feature); then tx_oe_o<=0 -> IDLE.
    - peer_oe_i=1 during RESP: tx_oe_o<=0 at that edge (bus freed next cycle), bus_conflict_o<=1 -> IDLE.
- Latency:
  - Byte on bus at edge N -> rx_valid_o high in cycle N+1.
  - Peer release seen at edge R -> tx_oe_o rises at edge R+TURNAROUND.
- Strobes are never asserted for more than one cycle.
- Reset mid-frame or mid-response aborts with no strobes; bus tri-stated from the next cycle.

Optional Feature:
- Macro: BUS_RESPONDER_CHECKSUM_EN.
- Defined: response is 2 bytes, ACK_BYTE then checksum_o; tx_oe_o high for 2 cycles.
- Undefined:
  - Response is ACK_BYTE only; tx_oe_o high for 1 cycle.
  - Checksum accumulator and checksum_o register are removed; checksum_o is tied to 8'h00.

Test Plan:
- Nominal (macro defined, defaults): peer drives 3A,01,02,03,04 then releases -> rx_valid_o 4 pulses with 01,02,03,04; frame_done_o with 04; checksum_o=0A; 2 idle cycles; then tx_oe_o=1 with bus 06 then 0A; then Z.
- Filler/SOF hunt: peer drives FF,FF,3A,10,20,30,40 -> no rx_valid_o for FF; payload 10..40; checksum_o=A0.
- Short frame: 3A,11,22 then peer_oe_i=0 -> two rx_valid_o, frame_err_o one pulse, no tx_oe_o, checksum_o keeps previous value.
- Checksum wrap: 3A,FF,FF,FF,04 -> checksum_o=01, response 06,01.
- Conflict: peer reasserts peer_oe_i during the ACK cycle -> tx_oe_o low next cycle, bus_conflict_o one pulse, state IDLE; a following 3A frame is accepted normally.
- Reset mid-payload after 3A,01: rst_i=1 one cycle -> all outputs zero, no frame_done_o; new frame 3A,05,05,05,05 -> checksum_o=14. With macro undefined, response is the single byte 06.
